// File: rtl/clint_axi_if.sv
// AXI4-Lite register-bus bundle for the CLINT: read, write-address, write-data
// and write-response channels.
interface clint_axi_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [2:0]  arprot;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [2:0]  awprot;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arvalid, arprot, rready,
        input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, arprot, rready,
        output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/clint_multi.sv
// Multi-hart core-local interruptor: prescaled 64-bit mtime, per-hart mtimecmp
// and msip, exposed over an AXI4-Lite slave.
module clint_multi #(
    parameter int unsigned NHART    = 4,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    clint_axi_if.slave        axi,
    output logic [63:0]       mtime,
    output logic [NHART-1:0]  time_intr,
    output logic [NHART-1:0]  soft_intr
);
    localparam int unsigned PW = 16;
    localparam int unsigned HW = (NHART > 1) ? $clog2(NHART) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [1:0] RESP_OK     = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {K_NONE, K_MSIP, K_CMP_LO, K_CMP_HI, K_MT_LO, K_MT_HI} kind_t;
    typedef struct packed {
        kind_t      kind;
        logic [3:0] hart;
    } dec_t;
    typedef enum logic {RIDLE, RRESP} rd_state_t;
    typedef enum logic {WIDLE, WRESP} wr_state_t;

    // Map a byte address to a register class; anything unmapped, unaligned or
    // beyond the configured hart count decodes to K_NONE.
    function automatic dec_t decode(input logic [31:0] a);
        dec_t d;
        d.kind = K_NONE;
        d.hart = a[5:2];
        if (a[31:16] == 16'h0 && a[1:0] == 2'b00) begin
            if (a[15:6] == 10'h0) begin
                d.kind = K_MSIP;
            end else if (a[15:7] == 9'h080) begin
                d.kind = a[2] ? K_CMP_HI : K_CMP_LO;
                d.hart = a[6:3];
            end else if (a[15:0] == 16'hBFF8) begin
                d.kind = K_MT_LO;
            end else if (a[15:0] == 16'hBFFC) begin
                d.kind = K_MT_HI;
            end
            if ((d.kind == K_MSIP || d.kind == K_CMP_LO || d.kind == K_CMP_HI) &&
                32'(d.hart) >= NHART) begin
                d.kind = K_NONE;
            end
        end
        return d;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = strb[i] ? nw[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

    logic [63:0]      mtimecmp [NHART];
    logic [NHART-1:0] msip;
    logic [PW-1:0]    presc;
    rd_state_t        rd_st;
    wr_state_t        wr_st;

    dec_t        rdec, wdec;
    logic [HW-1:0] ridx;
    logic [31:0] rd_word;
    logic        tick, wr_acc, wr_ok, mt_lo_wr, mt_hi_wr;
    logic [63:0] mtime_inc;

    logic unused_ok;
    assign unused_ok = ^{axi.arprot, axi.awprot, rdec.hart, wdec.hart};

    always_comb begin
        rdec    = decode(axi.araddr);
        wdec    = decode(axi.awaddr);
        ridx    = rdec.hart[HW-1:0];
        rd_word = '0;
        case (rdec.kind)
            K_MSIP:   rd_word = {31'h0, msip[ridx]};
            K_CMP_LO: rd_word = mtimecmp[ridx][31:0];
            K_CMP_HI: rd_word = mtimecmp[ridx][63:32];
            K_MT_LO:  rd_word = mtime[31:0];
            K_MT_HI:  rd_word = mtime[63:32];
            default:  rd_word = '0;
        endcase
        wr_acc    = (wr_st == WIDLE) && axi.awvalid && axi.wvalid;
        wr_ok     = wr_acc && (wdec.kind != K_NONE);
        mt_lo_wr  = wr_ok && (wdec.kind == K_MT_LO);
        mt_hi_wr  = wr_ok && (wdec.kind == K_MT_HI);
        tick      = (presc == PRESC_MAX);
        mtime_inc = mtime + 64'(tick);
    end

    // Timer: written bytes override the incremented value in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= '0;
            presc <= '0;
        end else begin
            mtime[63:32] <= mt_hi_wr ? merge(mtime_inc[63:32], axi.wdata, axi.wstrb)
                                     : mtime_inc[63:32];
            mtime[31:0]  <= mt_lo_wr ? merge(mtime_inc[31:0], axi.wdata, axi.wstrb)
                                     : mtime_inc[31:0];
            presc <= (tick || mt_lo_wr || mt_hi_wr) ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int h = 0; h < NHART; h++) begin
            if (rst) begin
                mtimecmp[h] <= '1;
                msip[h]     <= 1'b0;
            end else if (wr_ok && wdec.hart == 4'(h)) begin
                case (wdec.kind)
                    K_MSIP:   if (axi.wstrb[0]) msip[h] <= axi.wdata[0];
                    K_CMP_LO: mtimecmp[h][31:0]  <= merge(mtimecmp[h][31:0], axi.wdata, axi.wstrb);
                    K_CMP_HI: mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], axi.wdata, axi.wstrb);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_st       <= RIDLE;
            axi.arready <= 1'b1;
            axi.rvalid  <= 1'b0;
            axi.rdata   <= '0;
            axi.rresp   <= RESP_OK;
        end else begin
            case (rd_st)
                RIDLE: if (axi.arvalid) begin
                    rd_st       <= RRESP;
                    axi.arready <= 1'b0;
                    axi.rvalid  <= 1'b1;
                    axi.rdata   <= rd_word;
                    axi.rresp   <= (rdec.kind == K_NONE) ? RESP_SLVERR : RESP_OK;
                end
                RRESP: if (axi.rready) begin
                    rd_st       <= RIDLE;
                    axi.arready <= 1'b1;
                    axi.rvalid  <= 1'b0;
                end
                default: rd_st <= RIDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_st       <= WIDLE;
            axi.awready <= 1'b1;
            axi.wready  <= 1'b1;
            axi.bvalid  <= 1'b0;
            axi.bresp   <= RESP_OK;
        end else begin
            case (wr_st)
                WIDLE: if (wr_acc) begin
                    wr_st       <= WRESP;
                    axi.awready <= 1'b0;
                    axi.wready  <= 1'b0;
                    axi.bvalid  <= 1'b1;
                    axi.bresp   <= (wdec.kind == K_NONE) ? RESP_SLVERR : RESP_OK;
                end
                WRESP: if (axi.bready) begin
                    wr_st       <= WIDLE;
                    axi.awready <= 1'b1;
                    axi.wready  <= 1'b1;
                    axi.bvalid  <= 1'b0;
                end
                default: wr_st <= WIDLE;
            endcase
        end
    end

    always_comb begin
        for (int h = 0; h < NHART; h++) begin
            time_intr[h] = (mtime >= mtimecmp[h]);
        end
    end

    assign soft_intr = msip;

endmodule

// File: tb/tb_clint_multi.sv
// Scoreboard bench for clint_multi: directed scenarios plus random AXI traffic
// checked against an arithmetic timer/register model.
module tb_clint_multi;
    localparam int unsigned NH = 4;
    localparam int unsigned TD = 4;

    logic          clk;
    logic          rst;
    logic [63:0]   mtime;
    logic [NH-1:0] time_intr;
    logic [NH-1:0] soft_intr;

    clint_axi_if axi ();

    clint_multi #(.NHART(NH), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .axi(axi),
        .mtime(mtime), .time_intr(time_intr), .soft_intr(soft_intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: mtime after edge n is base + floor((n - n0)/TD), re-anchored on writes/reset.
    logic [63:0]   mt_base;
    int            mt_n0;
    logic [63:0]   m_cmp [NH];
    logic [NH-1:0] m_msip;
    logic [33:0]   rq [$];
    logic [1:0]    bq [$];

    logic [31:0] addrs [16] = '{32'h0000, 32'h0004, 32'h0008, 32'h000C, 32'h0010,
                                32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'h4018,
                                32'h401C, 32'h4020, 32'hBFF8, 32'hBFFC, 32'h1234, 32'h4001};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mt_at(input int n);
        return mt_base + 64'((n - mt_n0) / int'(TD));
    endfunction

    task automatic model_reset();
        mt_base = 64'h0;
        mt_n0   = cyc;
        m_msip  = '0;
        for (int h = 0; h < NH; h++) m_cmp[h] = '1;
    endtask

    // 0: unmapped/error, 1: msip, 2: mtimecmp, 3: mtime
    function automatic int region(input logic [31:0] a, output int h, output bit hi);
        h  = 0;
        hi = 1'b0;
        if (a % 32'd4 != 32'd0) return 0;
        if (a < 32'(4 * NH)) begin
            h = int'(a / 32'd4);
            return 1;
        end
        if (a >= 32'h4000 && a < 32'h4000 + 32'(8 * NH)) begin
            h  = int'((a - 32'h4000) / 32'd8);
            hi = ((a - 32'h4000) % 32'd8) != 32'd0;
            return 2;
        end
        if (a == 32'hBFF8 || a == 32'hBFFC) begin
            hi = (a == 32'hBFFC);
            return 3;
        end
        return 0;
    endfunction

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int h; bit hi; int k; logic [63:0] v;
        k = region(a, h, hi);
        d = 32'h0;
        r = (k == 0) ? 2'b10 : 2'b00;
        case (k)
            1: d = {31'h0, m_msip[h]};
            2: begin v = m_cmp[h]; d = hi ? v[63:32] : v[31:0]; end
            3: begin v = mt_at(cyc); d = hi ? v[63:32] : v[31:0]; end
            default: d = 32'h0;
        endcase
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                               input int n, output logic [1:0] r);
        int h; bit hi; int k; logic [63:0] v;
        k = region(a, h, hi);
        r = (k == 0) ? 2'b10 : 2'b00;
        case (k)
            1: if (ws[0]) m_msip[h] = wd[0];
            2: begin
                v = m_cmp[h];
                if (hi) v[63:32] = bmerge(v[63:32], wd, ws);
                else    v[31:0]  = bmerge(v[31:0], wd, ws);
                m_cmp[h] = v;
            end
            3: begin
                v = mt_at(n);
                if (hi) v[63:32] = bmerge(v[63:32], wd, ws);
                else    v[31:0]  = bmerge(v[31:0], wd, ws);
                mt_base = v;
                mt_n0   = n;
            end
            default: ;
        endcase
    endtask

    // Monitor: continuous timer/interrupt checks and scoreboard pops on handshakes.
    always @(negedge clk) begin : monitor
        logic [63:0]   m;
        logic [NH-1:0] et;
        logic [33:0]   e;
        logic [1:0]    eb;
        #1;
        if (chk_en) begin
            m = mt_at(cyc);
            for (int h = 0; h < NH; h++) et[h] = (m >= m_cmp[h]);
            chk("mtime", mtime, m);
            chk("time_intr", 64'(time_intr), 64'(et));
            chk("soft_intr", 64'(soft_intr), 64'(m_msip));
            if (axi.rvalid) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rvalid actual=1 required=0");
                end else if (axi.rready) begin
                    e = rq.pop_front();
                    chk("rdata", 64'(axi.rdata), 64'(e[31:0]));
                    chk("rresp", 64'(axi.rresp), 64'(e[33:32]));
                end
            end
            if (axi.bvalid) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bvalid actual=1 required=0");
                end else if (axi.bready) begin
                    eb = bq.pop_front();
                    chk("bresp", 64'(axi.bresp), 64'(eb));
                end
            end
        end
    end

    // Issue a read and/or write from a negedge; returns at a negedge once all responses retire.
    task automatic xact(input bit do_r, input logic [31:0] ra, input bit do_w,
                        input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                        input int rstall);
        bit rdn, wdn, racc, wacc;
        int t, n;
        logic [31:0] rexp_d;
        logic [1:0]  rexp_r, wexp;
        rdn = !do_r;
        wdn = !do_w;
        rexp_d = 32'h0;
        if (do_r) begin axi.araddr = ra; axi.arvalid = 1'b1; axi.rready = (rstall == 0); end
        if (do_w) begin
            axi.awaddr = wa; axi.wdata = wd; axi.wstrb = ws;
            axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
        end
        t = 0;
        while (!(rdn && wdn) && t < 20) begin
            racc = !rdn && axi.arready;
            wacc = !wdn && axi.awready && axi.wready;
            n = cyc + 1;
            if (racc) begin
                model_read(ra, rexp_d, rexp_r);
                rq.push_back({rexp_r, rexp_d});
            end
            @(posedge clk);
            if (wacc) begin
                model_write(wa, wd, ws, n, wexp);
                bq.push_back(wexp);
            end
            @(negedge clk);
            if (racc) begin axi.arvalid = 1'b0; rdn = 1'b1; end
            if (wacc) begin axi.awvalid = 1'b0; axi.wvalid = 1'b0; wdn = 1'b1; end
            t++;
        end
        if (!(rdn && wdn)) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=pending required=accepted");
            axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        end
        if (do_r) begin
            for (int i = 0; i < rstall; i++) begin
                chk("stall_rvalid", 64'(axi.rvalid), 64'h1);
                chk("stall_arready", 64'(axi.arready), 64'h0);
                chk("stall_rdata", 64'(axi.rdata), 64'(rexp_d));
                @(negedge clk);
            end
        end
        axi.rready = 1'b1;
        t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (rq.size() != 0 || bq.size() != 0) begin
            checks++; errors++;
            $display("FAIL resp_timeout actual=outstanding required=none");
            rq.delete();
            bq.delete();
        end
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        rst = 1'b1;
        axi.araddr = '0; axi.arvalid = 1'b0; axi.arprot = '0; axi.rready = 1'b1;
        axi.awaddr = '0; axi.awvalid = 1'b0; axi.awprot = '0;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_arready", 64'(axi.arready), 64'h1);
        chk("rst_awready", 64'(axi.awready), 64'h1);
        chk("rst_wready", 64'(axi.wready), 64'h1);
        chk("rst_rvalid", 64'(axi.rvalid), 64'h0);
        chk("rst_bvalid", 64'(axi.bvalid), 64'h0);
        chk("rst_rdata", 64'(axi.rdata), 64'h0);
        chk("rst_resp", 64'({axi.rresp, axi.bresp}), 64'h0);
        chk("rst_mtime", mtime, 64'h0);
        chk("rst_intr", 64'({time_intr, soft_intr}), 64'h0);
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;

        repeat (40) @(negedge clk);
        chk("mtime_after_40", mtime, 64'd10);
        xact(1, 32'hBFF8, 0, 32'h0, 32'h0, 4'h0, 0);

        // Hart 1 compare crossing
        xact(0, 32'h0, 1, 32'h4008, 32'h20, 4'hF, 0);
        xact(0, 32'h0, 1, 32'h400C, 32'h0, 4'hF, 0);
        xact(0, 32'h0, 1, 32'hBFF8, 32'h1F, 4'hF, 0);
        chk("pre_rise_intr", 64'(time_intr), 64'h0);
        t = 0;
        while (!time_intr[1] && t < 20) begin @(negedge clk); t++; end
        chk("time_intr_rise", 64'(time_intr), 64'h2);
        chk("mtime_at_rise", mtime, 64'h20);

        // Same-edge read and write of one register returns the old value
        xact(1, 32'h4008, 1, 32'h4008, 32'h55, 4'hF, 0);

        xact(0, 32'h0, 1, 32'h0008, 32'hFFFF_FFFF, 4'hF, 0);
        chk("soft_intr_set", 64'(soft_intr), 64'h4);
        xact(1, 32'h0008, 0, 32'h0, 32'h0, 4'h0, 0);
        xact(0, 32'h0, 1, 32'h0008, 32'h0, 4'hF, 0);
        chk("soft_intr_clr", 64'(soft_intr), 64'h0);

        xact(1, 32'h1234, 1, 32'h0010, 32'h1, 4'hF, 0);

        xact(1, 32'h4004, 0, 32'h0, 32'h0, 4'h0, 5);
        axi.awaddr = 32'h4000; axi.wdata = 32'h1; axi.wstrb = 4'hF; axi.awvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("aw_only_bvalid", 64'(axi.bvalid), 64'h0);
            chk("aw_only_awready", 64'(axi.awready), 64'h1);
        end
        axi.awvalid = 1'b0;
        xact(1, 32'h4000, 0, 32'h0, 32'h0, 4'h0, 0);

        // Byte write to mtime landing exactly on a tick edge
        xact(0, 32'h0, 1, 32'hBFFC, 32'h0, 4'hF, 0);
        xact(0, 32'h0, 1, 32'hBFF8, 32'h100, 4'hF, 0);
        t = 0;
        while (((cyc + 1 - mt_n0) % int'(TD)) != 0 && t < 10) begin @(negedge clk); t++; end
        chk("pre_tick_mtime", mtime, 64'h100);
        xact(0, 32'h0, 1, 32'hBFF8, 32'hFF, 4'b0001, 0);
        chk("tick_merge_mtime", mtime, 64'h1FF);

        // Reset in the middle of a read
        xact(0, 32'h0, 1, 32'h0000, 32'h1, 4'h1, 0);
        axi.araddr = 32'hBFF8; axi.arvalid = 1'b1; axi.rready = 1'b0;
        rq.push_back({2'b00, 32'h0});
        @(negedge clk);
        axi.arvalid = 1'b0;
        chk("pre_rst_rvalid", 64'(axi.rvalid), 64'h1);
        chk("pre_rst_intr", 64'({time_intr, soft_intr}), 64'h21);
        chk_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rvalid", 64'(axi.rvalid), 64'h0);
        chk("mid_rst_arready", 64'(axi.arready), 64'h1);
        chk("mid_rst_intr", 64'({time_intr, soft_intr}), 64'h0);
        rst = 1'b0;
        rq.delete();
        bq.delete();
        model_reset();
        chk_en = 1'b1;
        axi.rready = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_rvalid", 64'(axi.rvalid), 64'h0);

        for (int i = 0; i < 150; i++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            xact(mode != 1, addrs[$urandom_range(0, 15)],
                 mode != 0, addrs[$urandom_range(0, 15)],
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom,
                 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 6))) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
